// File: rtl/addsub_unit.sv
// Registered add/subtract unit with carry, signed-overflow, zero and negative flags.
// Optional signed saturation is compiled in with the ADDSUB_SATURATE_EN macro.
module addsub_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic             sub_i,
  input  logic             sat_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             zero_o,
  output logic             negative_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   raw;
  logic             ovf_next;
  logic [WIDTH-1:0] result_next;

  logic [WIDTH-1:0] result_reg;
  logic             carry_reg;
  logic             overflow_reg;
  logic             zero_reg;
  logic             negative_reg;
  logic             valid_reg;

  // Subtraction is a + ~b + 1, so carry-out doubles as "no borrow".
  always_comb begin
    b_eff       = sub_i ? ~b_i : b_i;
    raw         = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_i};
    ovf_next    = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (raw[WIDTH-1] != a_i[WIDTH-1]);
    result_next = raw[WIDTH-1:0];
`ifdef ADDSUB_SATURATE_EN
    // On overflow the true result has the sign of the operands.
    if (sat_i && ovf_next) begin
      result_next = a_i[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

`ifndef ADDSUB_SATURATE_EN
  logic unused_sat;
  assign unused_sat = sat_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_reg   <= '0;
      carry_reg    <= 1'b0;
      overflow_reg <= 1'b0;
      zero_reg     <= 1'b1;
      negative_reg <= 1'b0;
      valid_reg    <= 1'b0;
    end else begin
      valid_reg <= valid_i;
      if (valid_i) begin
        result_reg   <= result_next;
        carry_reg    <= raw[WIDTH];
        overflow_reg <= ovf_next;
        zero_reg     <= (result_next == '0);
        negative_reg <= result_next[WIDTH-1];
      end
    end
  end

  assign result_o   = result_reg;
  assign carry_o    = carry_reg;
  assign overflow_o = overflow_reg;
  assign zero_o     = zero_reg;
  assign negative_o = negative_reg;
  assign valid_o    = valid_reg;

endmodule

// File: tb/tb_addsub_unit.sv
// Directed self-checking bench for addsub_unit; expectations are hand-computed
// and follow the saturating variant when ADDSUB_SATURATE_EN is defined.
module tb_addsub_unit;
  localparam int WIDTH = 32;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             valid_i;
  logic             sub_i;
  logic             sat_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic [WIDTH-1:0] result_o;
  logic             carry_o;
  logic             overflow_o;
  logic             zero_o;
  logic             negative_o;
  logic             valid_o;

  int checks = 0;
  int fails  = 0;

  // Packed observation: {valid, result, carry, overflow, zero, negative}
  logic [WIDTH+4:0] got;
  logic [WIDTH+4:0] exp_v;

  always #5 clk_i = ~clk_i;

  addsub_unit #(.WIDTH(WIDTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .sub_i(sub_i), .sat_i(sat_i),
    .a_i(a_i), .b_i(b_i), .result_o(result_o), .carry_o(carry_o),
    .overflow_o(overflow_o), .zero_o(zero_o), .negative_o(negative_o), .valid_o(valid_o)
  );

  assign got = {valid_o, result_o, carry_o, overflow_o, zero_o, negative_o};

  function automatic logic [WIDTH+4:0] pack(input logic v, input logic [WIDTH-1:0] r,
                                            input logic c, input logic o,
                                            input logic z, input logic n);
    return {v, r, c, o, z, n};
  endfunction

  // Drive one operation at the falling edge; outputs are checked 1 ns after the next rise.
  task automatic drive_op(input logic s, input logic st,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk_i);
    valid_i = 1'b1; sub_i = s; sat_i = st; a_i = a; b_i = b;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk_i);
    valid_i = 1'b0; sub_i = 1'b0; sat_i = 1'b0; a_i = '1; b_i = '1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; valid_i = 1'b0; sub_i = 1'b0; sat_i = 1'b0; a_i = '0; b_i = '0;
    #1;
    exp_v = pack(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (got !== exp_v) begin
      fails++;
      $display("FAIL reset_state: got %h expected %h", got, exp_v);
    end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_basic_ops();
    drive_op(1'b0, 1'b0, 32'd5, 32'd7);
    exp_v = pack(1'b1, 32'd12, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (got !== exp_v) begin fails++; $display("FAIL add_5_7: got %h expected %h", got, exp_v); end
    else $display("add 5+7 -> %h", result_o);

    drive_op(1'b1, 1'b0, 32'h10, 32'h10);
    exp_v = pack(1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (got !== exp_v) begin fails++; $display("FAIL sub_equal: got %h expected %h", got, exp_v); end
    else $display("sub 0x10-0x10 -> %h", result_o);

    drive_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1);
    exp_v = pack(1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (got !== exp_v) begin fails++; $display("FAIL add_wrap: got %h expected %h", got, exp_v); end
    else $display("add 0xFFFFFFFF+1 -> %h", result_o);
  endtask

  task automatic test_saturate();
    drive_op(1'b0, 1'b1, 32'h7FFF_FFFF, 32'h1);
`ifdef ADDSUB_SATURATE_EN
    exp_v = pack(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);
`else
    exp_v = pack(1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
`endif
    checks++;
    if (got !== exp_v) begin fails++; $display("FAIL add_ovf_sat: got %h expected %h", got, exp_v); end
    else $display("add 0x7FFFFFFF+1 sat -> %h", result_o);
  endtask

  task automatic test_hold();
    drive_op(1'b1, 1'b0, 32'h0, 32'h1);
    exp_v = pack(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (got !== exp_v) begin fails++; $display("FAIL sub_0_1: got %h expected %h", got, exp_v); end
    else $display("sub 0-1 -> %h", result_o);
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      exp_v = pack(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (got !== exp_v) begin fails++; $display("FAIL hold_%0d: got %h expected %h", i, got, exp_v); end
      else $display("idle %0d held -> %h", i, result_o);
    end
  endtask

  task automatic test_back_to_back();
    logic             s_t  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic             st_t [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [WIDTH-1:0] a_t  [4] = '{32'd1, 32'd3, 32'h8000_0000, 32'h8000_0000};
    logic [WIDTH-1:0] b_t  [4] = '{32'd2, 32'd5, 32'h8000_0000, 32'h1};
    logic [WIDTH+4:0] e_t  [4];
    e_t[0] = pack(1'b1, 32'd3,          1'b0, 1'b0, 1'b0, 1'b0);
    e_t[1] = pack(1'b1, 32'hFFFF_FFFE,  1'b0, 1'b0, 1'b0, 1'b1);
    e_t[2] = pack(1'b1, 32'h0,          1'b1, 1'b1, 1'b1, 1'b0);
`ifdef ADDSUB_SATURATE_EN
    e_t[3] = pack(1'b1, 32'h8000_0000,  1'b1, 1'b1, 1'b0, 1'b1);
`else
    e_t[3] = pack(1'b1, 32'h7FFF_FFFF,  1'b1, 1'b1, 1'b0, 1'b0);
`endif
    for (int i = 0; i < 4; i++) begin
      drive_op(s_t[i], st_t[i], a_t[i], b_t[i]);
      checks++;
      if (got !== e_t[i]) begin fails++; $display("FAIL b2b_%0d: got %h expected %h", i, got, e_t[i]); end
      else $display("b2b %0d -> %h", i, result_o);
    end
  endtask

  task automatic test_async_reset();
    drive_op(1'b0, 1'b0, 32'd100, 32'd23);
    exp_v = pack(1'b1, 32'd123, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (got !== exp_v) begin fails++; $display("FAIL pre_reset_op: got %h expected %h", got, exp_v); end
    // Next operation is in flight when reset hits between edges.
    @(negedge clk_i);
    valid_i = 1'b1; sub_i = 1'b1; a_i = 32'd9; b_i = 32'd4;
    #2 rst_i = 1'b1;
    #1;
    exp_v = pack(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (got !== exp_v) begin fails++; $display("FAIL async_reset_now: got %h expected %h", got, exp_v); end
    else $display("async reset -> outputs cleared");
    @(negedge clk_i);
    rst_i = 1'b0; valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    checks++;
    if (got !== exp_v) begin fails++; $display("FAIL post_release_idle: got %h expected %h", got, exp_v); end
    drive_op(1'b1, 1'b0, 32'd9, 32'd4);
    exp_v = pack(1'b1, 32'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (got !== exp_v) begin fails++; $display("FAIL post_release_op: got %h expected %h", got, exp_v); end
    else $display("sub 9-4 after reset -> %h", result_o);
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_basic_ops();
    test_saturate();
    test_hold();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
